// File: rtl/ps2_mouse_init_sequencer.sv
// rtl/ps2_mouse_init_sequencer.sv - PS/2 mouse reset/self-test/configure/enable sequencer with retry
// Optional IntelliMouse knock and wheel detection when PS2_MOUSE_INIT_WHEEL_EN is defined.
module ps2_mouse_init_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES     = 2_500_000,
  parameter int unsigned BAT_TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter logic [7:0]  SAMPLE_RATE        = 8'd100
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       tx_done,
  input  logic       tx_error_no_ack,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       stream_enable,
  output logic       busy,
  output logic       init_fail,
  output logic [3:0] fail_code,
`ifdef PS2_MOUSE_INIT_WHEEL_EN
  output logic [1:0] attempt,
  output logic       wheel_mode
`else
  output logic [1:0] attempt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_TX, S_WAIT_RESP, S_WAIT_BAT, S_WAIT_ID, S_DONE, S_FAIL
  } state_t;

  localparam int CW = $clog2(BAT_TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] RSP_LIM = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] BAT_LIM = CW'(BAT_TIMEOUT_CYCLES - 1);

`ifdef PS2_MOUSE_INIT_WHEEL_EN
  localparam logic [3:0] LAST_STEP = 4'd10;
  localparam logic [3:0] ID_STEP   = 4'd9;
`else
  localparam logic [3:0] LAST_STEP = 4'd3;
`endif

  state_t        state, next_state;
  logic [3:0]    step, next_step;
  logic [CW-1:0] cnt;
  logic          resend_used, hp_seen;
  logic          timeout, rx_ok, retry, resend;
  logic [3:0]    retry_code;
  logic          tx_valid_d, stream_enable_d, busy_d, init_fail_d;
  logic [7:0]    tx_byte_d;
`ifdef PS2_MOUSE_INIT_WHEEL_EN
  logic          wheel_mode_d;
`endif

  function automatic logic [7:0] step_byte(input logic [3:0] s);
    case (s)
      4'd0:    step_byte = 8'hFF;
      4'd1:    step_byte = 8'hF3;
      4'd2:    step_byte = SAMPLE_RATE;
`ifdef PS2_MOUSE_INIT_WHEEL_EN
      4'd3:    step_byte = 8'hF3;
      4'd4:    step_byte = 8'hC8;
      4'd5:    step_byte = 8'hF3;
      4'd6:    step_byte = 8'h64;
      4'd7:    step_byte = 8'hF3;
      4'd8:    step_byte = 8'h50;
      4'd9:    step_byte = 8'hF2;
`endif
      default: step_byte = 8'hF4;
    endcase
  endfunction

  // State register plus the counters and flags that follow it
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      step        <= '0;
      cnt         <= '0;
      resend_used <= 1'b0;
      hp_seen     <= 1'b0;
      attempt     <= '0;
      fail_code   <= '0;
    end else begin
      state <= next_state;
      step  <= next_step;
      if (start || next_state != state) cnt <= '0;
      else if (cnt != '1)               cnt <= cnt + 1'b1;
      if (start || retry || next_step != step) resend_used <= 1'b0;
      else if (resend)                         resend_used <= 1'b1;
      hp_seen <= (state == S_DONE) && !start && (rx_valid ? (rx_byte == 8'hAA) : hp_seen);
      if (start) begin
        attempt   <= '0;
        fail_code <= '0;
      end else if (retry) begin
        fail_code <= retry_code;
        if (32'(attempt) < MAX_RETRIES) attempt <= attempt + 2'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    next_step  = step;
    retry      = 1'b0;
    retry_code = 4'd0;
    resend     = 1'b0;
    timeout    = (state == S_WAIT_BAT) ? (cnt >= BAT_LIM) : (cnt >= RSP_LIM);
    case (state)
      S_WAIT_RESP: rx_ok = (rx_byte == 8'hFA);
      S_WAIT_BAT:  rx_ok = (rx_byte == 8'hAA);
`ifdef PS2_MOUSE_INIT_WHEEL_EN
      S_WAIT_ID:   rx_ok = (rx_byte == 8'h00) || (step == ID_STEP && rx_byte == 8'h03);
`else
      S_WAIT_ID:   rx_ok = (rx_byte == 8'h00);
`endif
      default:     rx_ok = 1'b0;
    endcase
    if (start) begin
      next_state = S_SEND;
      next_step  = '0;
    end else begin
      case (state)
        S_SEND: if (tx_valid && tx_ready) next_state = S_WAIT_TX;
        S_WAIT_TX: begin
          if (tx_done) next_state = S_WAIT_RESP;
          else if (tx_error_no_ack) begin retry = 1'b1; retry_code = 4'd1; end
          else if (timeout)         begin retry = 1'b1; retry_code = 4'd5; end
        end
        S_WAIT_RESP, S_WAIT_BAT, S_WAIT_ID: begin
          if (rx_valid) begin
            if (rx_ok) begin
              if (state == S_WAIT_BAT) next_state = S_WAIT_ID;
              else if (state == S_WAIT_ID) begin
                next_state = S_SEND;
                next_step  = step + 4'd1;
              end else if (step == 4'd0) next_state = S_WAIT_BAT;
`ifdef PS2_MOUSE_INIT_WHEEL_EN
              else if (step == ID_STEP) next_state = S_WAIT_ID;
`endif
              else if (step == LAST_STEP) next_state = S_DONE;
              else begin
                next_state = S_SEND;
                next_step  = step + 4'd1;
              end
            end else if (rx_byte == 8'hFE) begin
              if (resend_used) begin retry = 1'b1; retry_code = 4'd2; end
              else begin
                resend     = 1'b1;
                next_state = S_SEND;
              end
            end else if (rx_byte == 8'hFC) begin retry = 1'b1; retry_code = 4'd3; end
            else                             begin retry = 1'b1; retry_code = 4'd4; end
          end else if (timeout) begin
            retry      = 1'b1;
            retry_code = 4'd5;
          end
        end
        // Hot-plugged mouse announces itself with AA 00; skip the reset command
        S_DONE: if (rx_valid && hp_seen && rx_byte == 8'h00) begin
          next_state = S_SEND;
          next_step  = 4'd1;
        end
        default: ;
      endcase
      if (retry) begin
        next_state = (32'(attempt) < MAX_RETRIES) ? S_SEND : S_FAIL;
        next_step  = '0;
      end
    end
  end

  always_comb begin
    tx_valid_d      = (state == S_SEND) && (next_state == S_SEND) && !start;
    tx_byte_d       = (state == S_SEND) ? step_byte(step) : tx_byte;
    stream_enable_d = (next_state == S_DONE);
    busy_d          = !(next_state inside {S_IDLE, S_DONE, S_FAIL});
    init_fail_d     = (next_state == S_FAIL);
`ifdef PS2_MOUSE_INIT_WHEEL_EN
    wheel_mode_d    = wheel_mode;
    if (!start && state == S_WAIT_ID && step == ID_STEP && rx_valid && rx_ok)
      wheel_mode_d = (rx_byte == 8'h03);
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      tx_valid      <= 1'b0;
      tx_byte       <= 8'h00;
      stream_enable <= 1'b0;
      busy          <= 1'b0;
      init_fail     <= 1'b0;
`ifdef PS2_MOUSE_INIT_WHEEL_EN
      wheel_mode    <= 1'b0;
`endif
    end else begin
      tx_valid      <= tx_valid_d;
      tx_byte       <= tx_byte_d;
      stream_enable <= stream_enable_d;
      busy          <= busy_d;
      init_fail     <= init_fail_d;
`ifdef PS2_MOUSE_INIT_WHEEL_EN
      wheel_mode    <= wheel_mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// tb/tb_ps2_mouse_init_sequencer.sv - scoreboard bench for the PS/2 mouse init sequencer
module tb_ps2_mouse_init_sequencer;
  logic       sys_clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0;
  logic       tx_ready = 1'b0, tx_done = 1'b0, tx_error_no_ack = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic       tx_valid, stream_enable, busy, init_fail;
  logic [3:0] fail_code;
  logic [1:0] attempt;
`ifdef PS2_MOUSE_INIT_WHEEL_EN
  logic       wheel_mode;
`endif

  int         n_vec = 0;
  int         n_miscmp = 0;
  logic [7:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  ps2_mouse_init_sequencer #(
    .TIMEOUT_CYCLES(100), .BAT_TIMEOUT_CYCLES(400), .MAX_RETRIES(3), .SAMPLE_RATE(8'd100)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_error_no_ack(tx_error_no_ack),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .stream_enable(stream_enable), .busy(busy), .init_fail(init_fail),
    .fail_code(fail_code),
`ifdef PS2_MOUSE_INIT_WHEEL_EN
    .attempt(attempt), .wheel_mode(wheel_mode)
`else
    .attempt(attempt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic reply(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge sys_clk);
    rx_valid = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  // Transmitter model: accept the pending request, then report ACK or no-ACK
  task automatic serve_tx(input logic err);
    int n = 0;
    logic [7:0] exp = 8'h00;
    while (!tx_valid && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("tx_valid_wait", tx_valid, 1);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    check_eq("tx_byte", tx_byte, exp);
    if (tx_valid) begin
      tx_ready = 1'b1;
      @(negedge sys_clk);
      tx_ready = 1'b0;
      check_eq("tx_valid_drop", tx_valid, 0);
      if (err) tx_error_no_ack = 1'b1;
      else     tx_done = 1'b1;
      @(negedge sys_clk);
      tx_done = 1'b0;
      tx_error_no_ack = 1'b0;
    end
  endtask

  task automatic run_reset();
    expect_tx(8'hFF); serve_tx(1'b0);
    reply(8'hFA); reply(8'hAA); reply(8'h00);
  endtask

  task automatic run_config();
    expect_tx(8'hF3); serve_tx(1'b0); reply(8'hFA);
    expect_tx(8'h64); serve_tx(1'b0); reply(8'hFA);
    expect_tx(8'hF4); serve_tx(1'b0);
    check_eq("se_before_ack", stream_enable, 0);
    reply(8'hFA);
    check_eq("se_after_ack", stream_enable, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge sys_clk);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_byte", tx_byte, 0);
    check_eq("rst_stream", stream_enable, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_init_fail", init_fail, 0);
    check_eq("rst_fail_code", fail_code, 0);
    check_eq("rst_attempt", attempt, 0);

    // Nominal
    pulse_start();
    run_reset();
    run_config();
    check_eq("nom_busy", busy, 0);
    check_eq("nom_attempt", attempt, 0);

    // Single resend then completion
    pulse_start();
    run_reset();
    expect_tx(8'hF3); serve_tx(1'b0); reply(8'hFE);
    expect_tx(8'hF3); serve_tx(1'b0); reply(8'hFA);
    expect_tx(8'h64); serve_tx(1'b0); reply(8'hFA);
    expect_tx(8'hF4); serve_tx(1'b0); reply(8'hFA);
    check_eq("rs_stream", stream_enable, 1);
    check_eq("rs_attempt", attempt, 0);

    // Second resend on the same step
    pulse_start();
    run_reset();
    expect_tx(8'hF3); serve_tx(1'b0); reply(8'hFE);
    expect_tx(8'hF3); serve_tx(1'b0); reply(8'hFE);
    expect_tx(8'hFF); serve_tx(1'b0);
    check_eq("rs2_fail_code", fail_code, 2);
    check_eq("rs2_attempt", attempt, 1);

    // Retry exhaustion
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      expect_tx(8'hFF); serve_tx(1'b1);
    end
    check_eq("ex_init_fail", init_fail, 1);
    check_eq("ex_fail_code", fail_code, 1);
    check_eq("ex_attempt", attempt, 3);
    check_eq("ex_busy", busy, 0);
    repeat (10) @(negedge sys_clk);
    check_eq("ex_quiet", tx_valid, 0);

    // Timeout after F4
    pulse_start();
    check_eq("to_init_fail_clr", init_fail, 0);
    run_reset();
    expect_tx(8'hF3); serve_tx(1'b0); reply(8'hFA);
    expect_tx(8'h64); serve_tx(1'b0); reply(8'hFA);
    expect_tx(8'hF4); serve_tx(1'b0);
    n = 0;
    while (!tx_valid && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("to_latency", n, 101);
    check_eq("to_fail_code", fail_code, 5);
    check_eq("to_attempt", attempt, 1);
    expect_tx(8'hFF); serve_tx(1'b0);

    // Hot-plug, including a broken AA x 00 pattern that must be ignored
    pulse_start();
    run_reset();
    run_config();
    reply(8'hAA); reply(8'h55); reply(8'h00);
    check_eq("hp_ignore_stream", stream_enable, 1);
    check_eq("hp_ignore_busy", busy, 0);
    reply(8'hAA);
    check_eq("hp_aa_stream", stream_enable, 1);
    reply(8'h00);
    check_eq("hp_drop_stream", stream_enable, 0);
    run_config();
    check_eq("hp_busy", busy, 0);

    // Start coincident with the self-test byte
    pulse_start();
    expect_tx(8'hFF); serve_tx(1'b1);
    expect_tx(8'hFF); serve_tx(1'b0);
    reply(8'hFA);
    check_eq("ms_attempt_pre", attempt, 1);
    start = 1'b1; rx_byte = 8'hAA; rx_valid = 1'b1;
    @(negedge sys_clk);
    start = 1'b0; rx_valid = 1'b0;
    expect_tx(8'hFF); serve_tx(1'b0);
    check_eq("ms_attempt", attempt, 0);
    check_eq("ms_fail_code", fail_code, 0);
    reply(8'hFA); reply(8'hAA); reply(8'h00);
    run_config();

    check_eq("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_init_sequencer.md
# ps2_mouse_init_sequencer

Power-up and recovery sequencer for the PS/2 mouse path. It drives the host-to-device byte transmitter and watches the received-byte stream. It runs the mouse reset / self-test / configure / enable-reporting sequence, then asserts `stream_enable` so the packet decoder may consume 3-byte movement packets. It retries on NACK, error, or timeout, and reports a sticky failure after a bounded number of attempts.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2_500_000: per-response wait limit in sys_clk cycles (25 ms at 100 MHz).
- `BAT_TIMEOUT_CYCLES`, default 100_000_000: wait limit for the self-test result (1 s).
- `MAX_RETRIES`, default 3: full-sequence restarts allowed before failure.
- `SAMPLE_RATE`, default 8'd100: value sent after the 0xF3 command.

Ports:
- `sys_clk` in 1: single clock for the block.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that (re)starts the sequence from any state.
- `tx_byte` out 8: byte to transmit; valid while `tx_valid` is high.
- `tx_valid` out 1: transmit request.
- `tx_ready` in 1: transmitter accepts the request.
- `tx_done` in 1: one-cycle pulse, frame sent and line ACK bit seen.
- `tx_error_no_ack` in 1: one-cycle pulse, frame sent but no line ACK.
- `rx_byte` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_byte`.
- `stream_enable` out 1: high in DONE; gates the packet decoder.
- `busy` out 1: high in every state except IDLE, DONE, FAIL.
- `init_fail` out 1: sticky, high in FAIL.
- `fail_code` out 4: cause of the last retry or failure.
- `attempt` out 2: current full-sequence attempt number, starting at 0.

## Operation
- Reset values:
  - state=IDLE.
  - `tx_valid`=0, `tx_byte`=0.
  - `stream_enable`=0, `busy`=0, `init_fail`=0.
  - `fail_code`=0, `attempt`=0.
  - Timeout counter=0.
- Transition from IDLE:
  - IDLE→SEND_RESET on `start`.
  - A `start` pulse in any other state: `attempt`←0, `fail_code`←0, go to SEND_RESET.
- Step list. Each SEND is followed by WAIT_TX, then WAIT_RESP.
  - SEND 0xFF, expect 0xFA.
  - WAIT_BAT: expect 0xAA.
  - WAIT_ID: expect 0x00.
  - SEND 0xF3, expect 0xFA.
  - SEND `SAMPLE_RATE`, expect 0xFA.
  - SEND 0xF4, expect 0xFA.
  - Then DONE.
- SEND state:
  - `tx_valid`=1 and `tx_byte` are held stable until the cycle where `tx_valid & tx_ready` (the handshake cycle).
  - After the handshake, go to WAIT_TX.
- WAIT_TX:
  - `tx_done` → WAIT_RESP.
  - `tx_error_no_ack` → retry with code 1.
- WAIT_RESP / WAIT_BAT / WAIT_ID, when `rx_valid`:
  - Expected byte → next step.
  - 0xFE (resend) → return to the same SEND step. Allowed once per step; a second 0xFE means retry with code 2.
  - 0xFC → retry with code 3.
  - Any other byte → retry with code 4.
- Timeout:
  - Counter clears on every state entry.
  - Reaching `TIMEOUT_CYCLES` → retry with code 5. WAIT_BAT uses `BAT_TIMEOUT_CYCLES` instead.
- Retry:
  - If `attempt` < `MAX_RETRIES`: `attempt`+=1, `fail_code` latched, go to SEND_RESET.
  - Otherwise go to FAIL.
- FAIL:
  - `init_fail`=1; leaves only on `reset` or `start`.
- DONE:
  - `stream_enable`=1 and all `rx_valid` are ignored, with one exception.
  - An `rx_valid` with 0xAA, followed by 0x00 as the next byte, means the mouse was hot-plugged. Set `stream_enable`←0 and go to SEND_F3, skipping the reset command.
- `rx_valid` in IDLE, SEND, or FAIL is ignored.

## Timing
- All outputs are registered.
- `tx_valid` rises the cycle after SEND entry.
- `stream_enable` rises the cycle after the final 0xFA strobe.
- `rx_valid` and a timeout in the same cycle: the byte wins.
- `start` coincident with `reset`: `reset` wins.
- `start` coincident with `rx_valid`: `start` wins and the byte is dropped.
- A request already accepted by the transmitter is not aborted by `start`. The sequencer ignores `tx_done` / `tx_error_no_ack` until it next reaches WAIT_TX.
- Timeout counter width is `$clog2(BAT_TIMEOUT_CYCLES+1)`. It saturates and never wraps.

## Configuration
- Macro: `PS2_MOUSE_INIT_WHEEL_EN`.
- Defined:
  - Before the final 0xF4 step, the IntelliMouse knock is inserted: F3/C8, F3/64, F3/50, each byte ACKed.
  - Then 0xF2 is sent, expecting 0xFA followed by an ID byte.
  - An output `wheel_mode` (1 bit, reset 0) is added. It is set to 1 if the ID is 0x03 and 0 if the ID is 0x00.
  - Any other ID means retry with code 4.
- Undefined: the sequence is as above and no `wheel_mode` port exists.

## Test plan
- Nominal start:
  - Stimulus: `start` pulse; model replies FA, AA, 00, FA, FA, FA.
  - Required: `tx_byte` order FF, F3, 64, F4.
  - Required: `stream_enable`=1 one cycle after the last FA.
  - Required: `busy`=0, `attempt`=0.
- Resend:
  - Stimulus: reply FE after the first F3, then FA.
  - Required: F3 is transmitted twice and the sequence completes.
  - Stimulus: a second FE on the same step.
  - Required: `fail_code`=2 and `attempt`=1.
- Retry exhaustion:
  - Stimulus: every WAIT_TX ends with `tx_error_no_ack`.
  - Required: 4 FF transmissions, then `init_fail`=1, `fail_code`=1, `attempt`=3.
- Timeout:
  - Stimulus: no reply after 0xF4, with `TIMEOUT_CYCLES`=100 for the test.
  - Required: retry starts exactly 100 cycles after WAIT_RESP entry, with `fail_code`=5.
- Hot-plug:
  - Stimulus: in DONE, inject AA then 00.
  - Required: `stream_enable` drops the cycle after 00, F3 is sent next, and DONE is re-entered after the ACKs.
- Mid-sequence start:
  - Stimulus: `start` asserted in WAIT_BAT at the same cycle as `rx_valid`=AA.
  - Required: byte dropped, next `tx_byte`=FF, `attempt`=0.
